// File: rtl/decode_execute_unit.sv
// Decode / register-file / execute stage of the five-stage MIPS-subset pipeline.
// Define MUL_EN to decode SPECIAL2 MUL (op 0x1C, funct 0x02); otherwise it is reported as invalid.
module decode_execute_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  input  logic        valid_insn,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_result,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch_taken,
  output logic [31:0] ex_target,
  output logic        ex_invalid
);

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
`ifdef MUL_EN
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] F_MUL       = 6'h02;
`endif

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        taken;
    logic [31:0] target;
    logic        invalid;
  } ex_t;

  logic        d_valid_q;
  logic [31:0] d_insn_q;
  logic [31:0] d_pc_q;
  logic [31:0] rf_q [32];
  ex_t         ex_q, ex_d;

  // Bit i of the big-endian numbering is bit (31-i) here.
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] a, b, sext, zext, pc4, pc8, btarget, jtarget;
  logic [4:0]  dest_c;
  logic        wr_c, ok_c;

  assign op      = d_insn_q[31:26];
  assign rs      = d_insn_q[25:21];
  assign rt      = d_insn_q[20:16];
  assign rd      = d_insn_q[15:11];
  assign shamt   = d_insn_q[10:6];
  assign funct   = d_insn_q[5:0];
  assign imm     = d_insn_q[15:0];
  assign sext    = {{16{imm[15]}}, imm};
  assign zext    = {16'h0000, imm};
  assign pc4     = d_pc_q + 32'd4;
  assign pc8     = d_pc_q + 32'd8;
  assign btarget = pc4 + (sext << 2);
  assign jtarget = {pc4[31:28], d_insn_q[25:0], 2'b00};

  // Write-through: a same-cycle writeback to the register being read wins over the array.
  always_comb begin
    a = rf_q[rs];
    if (rs == 5'd0)                          a = '0;
    else if (wb_en && (wb_addr == rs))       a = wb_data;
    b = rf_q[rt];
    if (rt == 5'd0)                          b = '0;
    else if (wb_en && (wb_addr == rt))       b = wb_data;
  end

  always_comb begin
    ex_d   = '0;
    dest_c = rd;
    wr_c   = 1'b0;
    ok_c   = 1'b1;
    unique case (op)
      OP_SPECIAL: begin
        wr_c = 1'b1;
        unique case (funct)
          F_ADD, F_ADDU: ex_d.result = a + b;
          F_SUB, F_SUBU: ex_d.result = a - b;
          F_AND:  ex_d.result = a & b;
          F_OR:   ex_d.result = a | b;
          F_XOR:  ex_d.result = a ^ b;
          F_NOR:  ex_d.result = ~(a | b);
          F_SLT:  ex_d.result = {31'd0, $signed(a) < $signed(b)};
          F_SLTU: ex_d.result = {31'd0, a < b};
          F_SLL:  ex_d.result = b << shamt;
          F_SRL:  ex_d.result = b >> shamt;
          F_SRA:  ex_d.result = $unsigned($signed(b) >>> shamt);
          F_SLLV: ex_d.result = b << a[4:0];
          F_SRLV: ex_d.result = b >> a[4:0];
          F_SRAV: ex_d.result = $unsigned($signed(b) >>> a[4:0]);
          F_JR: begin
            wr_c         = 1'b0;
            ex_d.taken   = 1'b1;
            ex_d.target  = a;
          end
          F_JALR: begin
            ex_d.taken   = 1'b1;
            ex_d.target  = a;
            ex_d.result  = pc8;
          end
          default: ok_c = 1'b0;
        endcase
      end
      OP_J: begin
        ex_d.taken  = 1'b1;
        ex_d.target = jtarget;
      end
      OP_JAL: begin
        dest_c      = 5'd31;
        wr_c        = 1'b1;
        ex_d.taken  = 1'b1;
        ex_d.target = jtarget;
        ex_d.result = pc8;
      end
      OP_BEQ, OP_BNE: begin
        dest_c      = rt;
        ex_d.target = btarget;
        ex_d.taken  = (op == OP_BEQ) ? (a == b) : (a != b);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dest_c = rt;
        wr_c   = 1'b1;
        unique case (op)
          OP_SLTI:  ex_d.result = {31'd0, $signed(a) < $signed(sext)};
          OP_SLTIU: ex_d.result = {31'd0, a < sext};
          OP_ANDI:  ex_d.result = a & zext;
          OP_ORI:   ex_d.result = a | zext;
          OP_XORI:  ex_d.result = a ^ zext;
          OP_LUI:   ex_d.result = {imm, 16'h0000};
          default:  ex_d.result = a + sext;
        endcase
      end
      OP_LW: begin
        dest_c      = rt;
        wr_c        = 1'b1;
        ex_d.mem_rd = 1'b1;
        ex_d.result = a + sext;
      end
      OP_SW: begin
        dest_c          = rt;
        ex_d.mem_wr     = 1'b1;
        ex_d.result     = a + sext;
        ex_d.store_data = b;
      end
`ifdef MUL_EN
      OP_SPECIAL2: begin
        if (funct == F_MUL) begin
          wr_c        = 1'b1;
          ex_d.result = a * b;
        end else begin
          ok_c = 1'b0;
        end
      end
`endif
      default: ok_c = 1'b0;
    endcase
    ex_d.valid  = 1'b1;
    ex_d.pc     = d_pc_q;
    ex_d.dest   = dest_c;
    ex_d.reg_we = wr_c && (dest_c != 5'd0);
    if (!ok_c) begin
      ex_d         = '0;
      ex_d.valid   = 1'b1;
      ex_d.invalid = 1'b1;
      ex_d.pc      = d_pc_q;
    end
    if (!d_valid_q) ex_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_valid_q <= 1'b0;
      d_insn_q  <= '0;
      d_pc_q    <= '0;
      ex_q      <= '0;
    end else if (!stall) begin
      d_valid_q <= valid_insn;
      d_insn_q  <= insn;
      d_pc_q    <= pc;
      ex_q      <= ex_d;
    end
  end

  // Writeback is independent of stall so the held instruction sees fresh operands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_pc           = ex_q.pc;
  assign ex_result       = ex_q.result;
  assign ex_store_data   = ex_q.store_data;
  assign ex_dest         = ex_q.dest;
  assign ex_reg_we       = ex_q.reg_we;
  assign ex_mem_rd       = ex_q.mem_rd;
  assign ex_mem_wr       = ex_q.mem_wr;
  assign ex_branch_taken = ex_q.taken;
  assign ex_target       = ex_q.target;
  assign ex_invalid      = ex_q.invalid;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed scoreboard bench for decode_execute_unit: expectations queued at issue, checked two edges later.
module tb_decode_execute_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] insn = '0;
  logic [31:0] pc = '0;
  logic        valid_insn = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch_taken, ex_invalid;
  logic [31:0] ex_pc, ex_result, ex_store_data, ex_target;
  logic [4:0]  ex_dest;

  always #5 clock = ~clock;

  decode_execute_unit dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .insn(insn), .pc(pc), .valid_insn(valid_insn),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_we(ex_reg_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target), .ex_invalid(ex_invalid)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        we, mrd, mwr, tk;
    logic [31:0] tgt;
    logic        inv;
    logic        cd;   // compare pc/result/dest
    logic        ct;   // compare target
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;

  function automatic exp_t mk(logic v, logic [31:0] p, logic [31:0] res, logic [31:0] sd,
                              logic [4:0] dest, logic we, logic mrd, logic mwr, logic tk,
                              logic [31:0] tgt, logic inv, logic cd, logic ct);
    exp_t e;
    e.v = v; e.pc = p; e.res = res; e.sd = sd; e.dest = dest; e.we = we;
    e.mrd = mrd; e.mwr = mwr; e.tk = tk; e.tgt = tgt; e.inv = inv; e.cd = cd; e.ct = ct;
    return e;
  endfunction

  function automatic exp_t alu(logic [31:0] p, logic [31:0] res, logic [4:0] dest);
    return mk(1'b1, p, res, 32'h0, dest, dest != 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic exp_t zero_exp();
    return mk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic exp_t invalid_exp(logic [31:0] p);
    return mk(1'b1, p, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    chk({tag, ".valid"},   {31'd0, ex_valid},        {31'd0, e.v});
    chk({tag, ".reg_we"},  {31'd0, ex_reg_we},       {31'd0, e.we});
    chk({tag, ".mem_rd"},  {31'd0, ex_mem_rd},       {31'd0, e.mrd});
    chk({tag, ".mem_wr"},  {31'd0, ex_mem_wr},       {31'd0, e.mwr});
    chk({tag, ".taken"},   {31'd0, ex_branch_taken}, {31'd0, e.tk});
    chk({tag, ".invalid"}, {31'd0, ex_invalid},      {31'd0, e.inv});
    if (e.cd) begin
      chk({tag, ".pc"},     ex_pc,             e.pc);
      chk({tag, ".result"}, ex_result,         e.res);
      chk({tag, ".dest"},   {27'd0, ex_dest},  {27'd0, e.dest});
    end
    if (e.ct) chk({tag, ".target"}, ex_target, e.tgt);
    if (e.mwr || !e.v) chk({tag, ".store_data"}, ex_store_data, e.sd);
  endtask

  task automatic pop_check(input string tag);
    chk({tag, ".sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) check_exp(tag, sb.pop_front());
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clock); #1;
    wb_en = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] p, input exp_t e);
    insn = i; pc = p; valid_insn = 1'b1;
    sb.push_back(e);
    @(posedge clock); #1;
    valid_insn = 1'b0; insn = '0;
    @(posedge clock); #1;
    pop_check(tag);
  endtask

  initial begin
    exp_t eadd;

    #12;
    sb.push_back(zero_exp());
    pop_check("reset");
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // ADD then SUB back to back; stall while SUB sits in D and $2 changes underneath it
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    eadd = alu(32'h100, 32'd12, 5'd3);
    insn = 32'h00221820; pc = 32'h100; valid_insn = 1'b1;
    sb.push_back(eadd);
    @(posedge clock); #1;
    insn = 32'h00417822; pc = 32'h104;
    sb.push_back(alu(32'h104, 32'd95, 5'd15));
    @(posedge clock); #1;
    pop_check("add");
    stall = 1'b1; valid_insn = 1'b0; insn = '0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      wb_en = 1'b0;
      check_exp("stall_hold", eadd);
    end
    stall = 1'b0;
    @(posedge clock); #1;
    pop_check("sub_after_stall");

`ifdef MUL_EN
    issue("mul", 32'h70228002, 32'h110, alu(32'h110, 32'd500, 5'd16));
`else
    issue("mul_unsupported", 32'h70228002, 32'h110, invalid_exp(32'h110));
`endif

    wb(5'd1, 32'hFFFF_FFFF);
    wb(5'd2, 32'd1);
    issue("addiu_wrap", 32'h24240001, 32'h120, alu(32'h120, 32'd0, 5'd4));
    issue("slt",        32'h0022282A, 32'h124, alu(32'h124, 32'd1, 5'd5));
    issue("sltu",       32'h0022282B, 32'h128, alu(32'h128, 32'd0, 5'd5));

    issue("beq", 32'h10210004, 32'h8002_0000,
          mk(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8002_0014, 1'b0, 1'b0, 1'b1));
    issue("bne", 32'h14210004, 32'h8002_0000,
          mk(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
    issue("jal", 32'h0C008000, 32'h8002_0010,
          mk(1'b1, 32'h8002_0010, 32'h8002_0018, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1,
             32'h8002_0000, 1'b0, 1'b1, 1'b1));

    wb(5'd0, 32'd9);
    issue("zero_reg", 32'h00004020, 32'h130, alu(32'h130, 32'd0, 5'd8));

    // Writeback to $6 lands during the cycle the instruction reads $6
    wb(5'd6, 32'h55);
    insn = 32'h00C03820; pc = 32'h400; valid_insn = 1'b1;
    sb.push_back(alu(32'h400, 32'h1234, 5'd7));
    @(posedge clock); #1;
    valid_insn = 1'b0; insn = '0;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h1234;
    @(posedge clock); #1;
    wb_en = 1'b0;
    pop_check("bypass");

    issue("sw", 32'hAC220008, 32'h140,
          mk(1'b1, 32'h140, 32'd7, 32'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
    issue("lw", 32'h8C49FFFC, 32'h144,
          mk(1'b1, 32'h144, 32'hFFFF_FFFD, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));

    wb(5'd11, 32'h8000_0000);
    issue("sra", 32'h000B5103, 32'h150, alu(32'h150, 32'hF800_0000, 5'd10));
    issue("lui", 32'h3C0CABCD, 32'h154, alu(32'h154, 32'hABCD_0000, 5'd12));

    wb(5'd13, 32'h0040_0100);
    issue("jr", 32'h01A00008, 32'h200,
          mk(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b1));
    issue("jalr", 32'h01A07009, 32'h300,
          mk(1'b1, 32'h300, 32'h308, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b1, 1'b1));
    issue("addi_dest0", 32'h20400005, 32'h310,
          mk(1'b1, 32'h310, 32'd6, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));

    issue("bad_opcode", 32'hFC000000, 32'h320, invalid_exp(32'h320));

    insn = 32'h00221820; pc = 32'h330; valid_insn = 1'b0;
    sb.push_back(zero_exp());
    @(posedge clock); #1;
    @(posedge clock); #1;
    pop_check("valid_low");

    // Reset with one instruction in EX and another in D
    insn = 32'h00221820; pc = 32'h500; valid_insn = 1'b1;
    @(posedge clock); #1;
    insn = 32'h00417822; pc = 32'h504;
    @(posedge clock); #1;
    valid_insn = 1'b0; insn = '0;
    reset_n = 1'b0;
    #1;
    sb.push_back(zero_exp());
    pop_check("reset_mid_ex");
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    sb.push_back(zero_exp());
    pop_check("reset_mid_d");
    issue("regs_cleared", 32'h002D1820, 32'h600, alu(32'h600, 32'd0, 5'd3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
